// File: rtl/spi_cfg_rx_if.sv
// spi_cfg_rx_if
//   Bundles the SPI pins, the register-file read port and the write/error
//   report outputs of spi_cfg_rx.
//
//   sck, sdi, cs_n   SPI clock, serial data (MSB first), chip select (active low)
//   rd_addr          register file read address
//   rd_data          registered read data
//   wr_valid         one-cycle pulse per committed frame
//   wr_addr/wr_data  last committed address/data, held until next commit
//   frame_err        one-cycle pulse per rejected frame
//   busy             high while a frame is being shifted or committed
//   frame_count      committed frame counter, wraps at 256
//
//   slave  : used by the responder (spi_cfg_rx)
//   master : used by whatever drives the SPI pins and reads the results
interface spi_cfg_rx_if;
    logic        sck;
    logic        sdi;
    logic        cs_n;
    logic [3:0]  rd_addr;
    logic [27:0] rd_data;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [27:0] wr_data;
    logic        frame_err;
    logic        busy;
    logic [7:0]  frame_count;

    modport slave (
        input  sck, sdi, cs_n, rd_addr,
        output rd_data, wr_valid, wr_addr, wr_data, frame_err, busy, frame_count
    );

    modport master (
        output sck, sdi, cs_n, rd_addr,
        input  rd_data, wr_valid, wr_addr, wr_data, frame_err, busy, frame_count
    );
endinterface

// File: rtl/spi_cfg_rx.sv
// spi_cfg_rx
//   SPI responder for 32-bit configuration frames (28 data bits followed by a
//   4-bit address, MSB first). Complete 32-bit frames are written into a
//   16 x 28 register file; frames of any other length are rejected.
//
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  spi_cfg_rx_if.slave: SPI pins, read port, write/error reports
//
//   SYNC_STAGES  synchronizer depth on sck, sdi and cs_n (minimum 2)
module spi_cfg_rx #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    spi_cfg_rx_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Synchronizers and edge-detect delay flops
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sck_dly_q;
    logic                   cs_dly_q;

    logic sck_s;
    logic sdi_s;
    logic cs_s;
    logic sck_rise;
    logic cs_fall;
    logic cs_rise;

    // Frame datapath and state
    state_t      state_q;
    logic [31:0] shift_q;
    logic [31:0] shift_d;
    logic [5:0]  bit_cnt_q;
    logic [5:0]  bit_cnt_d;
    logic [27:0] regs_q [16];

    // Registered outputs
    logic [27:0] rd_data_q;
    logic        wr_valid_q;
    logic [3:0]  wr_addr_q;
    logic [27:0] wr_data_q;
    logic        frame_err_q;
    logic        err_pend_q;
    logic        busy_q;
    logic [7:0]  frame_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q <= '0;
            sdi_sync_q <= '0;
            cs_sync_q  <= '0;
            sck_dly_q  <= 1'b0;
            cs_dly_q   <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
            sck_dly_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_dly_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;

    always_comb begin
        shift_d   = {shift_q[30:0], sdi_s};
        bit_cnt_d = (bit_cnt_q >= 6'd33) ? 6'd33 : bit_cnt_q + 6'd1;
    end

    // Frame FSM. A rejected frame leaves SHIFT immediately (busy drops) but
    // its error pulse is delayed one cycle through err_pend_q so frame_err
    // lines up with where wr_valid would have appeared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_err_q   <= 1'b0;
            err_pend_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_valid_q  <= 1'b0;
            frame_err_q <= err_pend_q;
            err_pend_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end

                SHIFT: begin
                    // cs_rise takes priority; a coincident sck_rise is dropped
                    if (cs_rise) begin
                        if (bit_cnt_q == 6'd32) begin
                            state_q <= COMMIT;
                        end else begin
                            err_pend_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end else if (sck_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_d;
                    end
                end

                COMMIT: begin
                    regs_q[shift_q[3:0]] <= shift_q[31:4];
                    wr_addr_q            <= shift_q[3:0];
                    wr_data_q            <= shift_q[31:4];
                    wr_valid_q           <= 1'b1;
                    frame_count_q        <= frame_count_q + 8'd1;
                    busy_q               <= 1'b0;
                    state_q              <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Read port: a same-cycle commit to rd_addr returns the old contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= regs_q[bus.rd_addr];
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;
    assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_spi_cfg_rx.sv
// tb_spi_cfg_rx
//   Directed bench for spi_cfg_rx: configuration sequence, short and long
//   frames, read-during-write, mid-frame reset and frame counter wrap.
module tb_spi_cfg_rx;

    logic clk;
    logic rst;

    spi_cfg_rx_if bus ();

    spi_cfg_rx #(.SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Results gathered by end_frame
    int unsigned n_wr;
    int unsigned n_err;
    logic [27:0] rd_at_commit;
    logic [27:0] rd_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_clks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        bus.cs_n = 1'b0;
        wait_clks(4);
    endtask

    // Sends v[32], v[31], ... for nbits bits; sck half period is 3 clks
    task automatic shift_bits(input logic [32:0] v, input int unsigned nbits);
        for (int unsigned k = 0; k < nbits; k++) begin
            bus.sdi = v[32-k];
            wait_clks(3);
            bus.sck = 1'b1;
            wait_clks(3);
            bus.sck = 1'b0;
        end
    endtask

    // Raises cs_n and watches a bounded window for the commit/error pulse
    task automatic end_frame();
        logic prev_wr;
        wait_clks(3);
        bus.cs_n = 1'b1;
        n_wr = 0;
        n_err = 0;
        prev_wr = 1'b0;
        for (int unsigned i = 0; i < 14; i++) begin
            @(negedge clk);
            if (prev_wr) rd_next = bus.rd_data;
            prev_wr = bus.wr_valid;
            if (bus.wr_valid) begin
                n_wr++;
                rd_at_commit = bus.rd_data;
            end
            if (bus.frame_err) n_err++;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        start_frame();
        shift_bits({w, 1'b0}, 32);
        end_frame();
    endtask

    task automatic read_reg(input logic [3:0] a, output logic [27:0] d);
        @(negedge clk);
        bus.rd_addr = a;
        wait_clks(2);
        d = bus.rd_data;
    endtask

    logic [31:0] cfg [5];
    logic [27:0] cfg_data [5];
    logic [27:0] rdv;
    logic [31:0] w;

    initial begin
        cfg[0] = 32'hA2919A30; cfg_data[0] = 28'hA2919A3;
        cfg[1] = 32'h0550C8C1; cfg_data[1] = 28'h0550C8C;
        cfg[2] = 32'hEAFF1DC2; cfg_data[2] = 28'hEAFF1DC;
        cfg[3] = 32'h9EC00083; cfg_data[3] = 28'h9EC0008;
        cfg[4] = 32'h7AC06004; cfg_data[4] = 28'h7AC0600;

        rst = 1'b1;
        bus.sck = 1'b0;
        bus.sdi = 1'b0;
        bus.cs_n = 1'b1;
        bus.rd_addr = 4'd0;
        wait_clks(3);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_count", 32'(bus.frame_count), 32'd0);
        check("reset_wr_valid", 32'(bus.wr_valid), 32'd0);
        rst = 1'b0;
        wait_clks(6);

        // Configuration sequence
        start_frame();
        check("busy_in_shift", 32'(bus.busy), 32'd1);
        shift_bits({cfg[0], 1'b0}, 32);
        end_frame();
        check("busy_after", 32'(bus.busy), 32'd0);
        check("cfg0_wr", n_wr, 1);
        check("cfg0_addr", 32'(bus.wr_addr), 32'd0);
        check("cfg0_data", 32'(bus.wr_data), 32'(cfg_data[0]));
        for (int i = 1; i < 5; i++) begin
            send_word(cfg[i]);
            check($sformatf("cfg%0d_wr", i), n_wr, 1);
            check($sformatf("cfg%0d_err", i), n_err, 0);
            check($sformatf("cfg%0d_addr", i), 32'(bus.wr_addr), 32'(i));
            check($sformatf("cfg%0d_data", i), 32'(bus.wr_data), 32'(cfg_data[i]));
        end
        check("cfg_count", 32'(bus.frame_count), 32'd5);
        for (int i = 0; i < 5; i++) begin
            read_reg(4'(i), rdv);
            check($sformatf("cfg_rd%0d", i), 32'(rdv), 32'(cfg_data[i]));
        end

        // Short frame: 31 bits
        start_frame();
        shift_bits({32'h12345675, 1'b0}, 31);
        end_frame();
        check("short_err", n_err, 1);
        check("short_wr", n_wr, 0);
        check("short_count", 32'(bus.frame_count), 32'd5);
        read_reg(4'd5, rdv);
        check("short_rd5", 32'(rdv), 32'd0);
        read_reg(4'd2, rdv);
        check("short_rd2", 32'(rdv), 32'h0EAFF1DC);

        // Long frame: 33 bits, then a valid frame to address 7
        start_frame();
        shift_bits({32'hDEADBEE7, 1'b1}, 33);
        end_frame();
        check("long_err", n_err, 1);
        check("long_wr", n_wr, 0);
        send_word(32'h0ABCDEF7);
        check("after_long_wr", n_wr, 1);
        check("after_long_err", n_err, 0);
        check("after_long_addr", 32'(bus.wr_addr), 32'd7);
        check("after_long_count", 32'(bus.frame_count), 32'd6);
        read_reg(4'd7, rdv);
        check("after_long_rd7", 32'(rdv), 32'h00ABCDEF);

        // Read during write at address 3
        @(negedge clk);
        bus.rd_addr = 4'd3;
        send_word(32'h12345673);
        check("rdw1_old", 32'(rd_at_commit), 32'h09EC0008);
        check("rdw1_new", 32'(rd_next), 32'h01234567);
        send_word(32'hFEDCBA93);
        check("rdw2_old", 32'(rd_at_commit), 32'h01234567);
        check("rdw2_new", 32'(rd_next), 32'h0FEDCBA9);
        check("rdw_count", 32'(bus.frame_count), 32'd8);

        // Reset mid-frame
        start_frame();
        shift_bits({32'hCAFEF00D, 1'b0}, 16);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus.frame_count), 32'd0);
        check("mid_rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("mid_rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_flags", {30'd0, bus.wr_valid, bus.frame_err}, 32'd0);
        @(negedge clk);
        bus.cs_n = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(6);
        send_word(32'h55555552);
        check("post_rst_wr", n_wr, 1);
        check("post_rst_addr", 32'(bus.wr_addr), 32'd2);
        check("post_rst_count", 32'(bus.frame_count), 32'd1);
        read_reg(4'd3, rdv);
        check("post_rst_rd3", 32'(rdv), 32'd0);

        // Counter wrap over 256 frames
        @(negedge clk);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(6);
        check("wrap_start", 32'(bus.frame_count), 32'd0);
        for (int i = 0; i < 256; i++) begin
            w = {28'hC0FFEE0 + 28'(i), 4'(i)};
            send_word(w);
            if (i == 254) check("wrap_255", 32'(bus.frame_count), 32'd255);
        end
        check("wrap_0", 32'(bus.frame_count), 32'd0);
        wait_clks(10);
        check("wrap_hold_addr", 32'(bus.wr_addr), 32'hF);
        check("wrap_hold_data", 32'(bus.wr_data), 32'h0C0FFFDF);
        read_reg(4'hF, rdv);
        check("wrap_rd15", 32'(rdv), 32'h0C0FFFDF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_cfg_rx.md
# spi_cfg_rx

SPI responder that receives the 32-bit configuration frames our SPI transmitter sends to the GNSS front end. Each frame carries 28 data bits followed by a 4-bit register address. The block stores each frame in a 16-entry register file and reports every write and every framing error. It is the bench-side model of the front end's configuration port, and it also lets the FPGA loop back and check its own configuration sequence in hardware.

## Interface
Parameters:
- SYNC_STAGES, default 2: number of synchronizer flops on each of sck, sdi and cs_n (minimum 2).

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: reset, asynchronous and active-high.
- sck, input, 1: SPI clock, asynchronous to clk.
- sdi, input, 1: SPI serial data, MSB first.
- cs_n, input, 1: SPI chip select, active-low.
- rd_addr, input, 4: register file read address.
- rd_data, output, 28: registered read data.
- wr_valid, output, 1: one-cycle pulse when a frame is committed.
- wr_addr, output, 4: address of the committed frame. Held until the next commit.
- wr_data, output, 28: data of the committed frame. Held until the next commit.
- frame_err, output, 1: one-cycle pulse when a frame is rejected.
- busy, output, 1: high while in the SHIFT or COMMIT state.
- frame_count, output, 8: count of committed frames. Wraps at 256.

## Operation
- Synchronizers:
  - sck, sdi and cs_n each pass through SYNC_STAGES flops; the last stage gives sck_s, sdi_s and cs_s.
  - Each synchronized signal also has one delay flop: sck_d and cs_d.
  - sck_rise = sck_s & ~sck_d.
  - cs_fall = ~cs_s & cs_d.
  - cs_rise = cs_s & ~cs_d.
- Frame format, received MSB first: bits [31:4] are data, bits [3:0] are address.
- Datapath:
  - shift_reg, 32 bits.
  - bit_cnt, 6 bits, saturates at 33.
  - regs, 16 entries of 28 bits.
- State machine:
  - IDLE:
    - On cs_fall: clear shift_reg and bit_cnt, go to SHIFT.
    - sck edges in IDLE are ignored.
  - SHIFT:
    - On sck_rise: shift_reg <= {shift_reg[30:0], sdi_s} and bit_cnt <= min(bit_cnt+1, 33).
    - On cs_rise with bit_cnt == 32: go to COMMIT.
    - On cs_rise with any other bit_cnt: pulse frame_err, go to IDLE, leave regs unchanged.
    - An sck_rise in the same cycle as cs_rise is ignored.
  - COMMIT (one cycle):
    - regs[shift_reg[3:0]] <= shift_reg[31:4].
    - wr_addr <= shift_reg[3:0] and wr_data <= shift_reg[31:4].
    - Pulse wr_valid.
    - frame_count <= frame_count + 1, modulo 256.
    - Go to IDLE.
- Read port: rd_data <= regs[rd_addr] every cycle.
- Read during a write to the same address:
  - In the COMMIT cycle, rd_data is loaded with the old value.
  - The new value appears one cycle later.
- Reset, asserted at any time including mid-frame:
  - State goes to IDLE.
  - shift_reg, bit_cnt, all regs and all synchronizer and delay flops go to 0.
  - rd_data, wr_valid, wr_addr, wr_data, frame_err, busy and frame_count go to 0.
  - No partial frame is ever committed.
- After reset release, if cs_n is idle high, the synchronizer chain rising from 0 produces a cs_rise. That cs_rise occurs in IDLE and is ignored.

## Timing
- Minimum SPI timing:
  - sck high time and low time are each at least SYNC_STAGES+1 clk periods.
  - sdi is stable from SYNC_STAGES+1 clk periods before each sck rising edge until SYNC_STAGES+1 clk periods after it.
  - cs_n fall to first sck rise is at least SYNC_STAGES+2 clk periods.
  - Last sck rise to cs_n rise is at least SYNC_STAGES+2 clk periods.
- Shift latency: each sck rising edge is shifted SYNC_STAGES+1 clk edges after the first clk edge that samples sck high.
- Commit latency: wr_valid is high in the cycle that starts SYNC_STAGES+2 clk edges after the first clk edge sampling cs_n high.
  - With SYNC_STAGES=2, that is the 4th edge.
  - frame_err has the same latency as wr_valid.
- busy:
  - Rises on the edge that enters SHIFT.
  - Falls on the edge that leaves COMMIT, or leaves SHIFT on error.
- Back-to-back frames: cs_n high time is at least SYNC_STAGES+3 clk periods. A cs_fall arriving during COMMIT is lost and must not occur.

## Test plan
- Config sequence: send five frames 32'hA2919A30, 32'h0550C8C1, 32'hEAFF1DC2, 32'h9EC00083 and 32'h7AC06004.
  - wr_valid pulses 5 times, with wr_addr 0 through 4.
  - Reading rd_addr 0 through 4 returns 28'hA2919A3, 28'h0550C8C, 28'hEAFF1DC, 28'h9EC0008 and 28'h7AC0600.
  - frame_count = 5.
- Short frame: send 31 bits, then raise cs_n.
  - frame_err pulses once, with no wr_valid.
  - regs and frame_count are unchanged.
- Long frame: send 33 bits.
  - frame_err pulses once.
  - The next valid 32-bit frame to address 7 commits normally.
- Read during write: hold rd_addr = 3 and write 28'h1234567, then 28'hFEDCBA9.
  - In the second COMMIT cycle, rd_data is 28'h1234567.
  - The following cycle, rd_data is 28'hFEDCBA9.
- Reset mid-frame: assert rst after 16 bits.
  - All outputs go to 0 immediately.
  - After release, a new complete frame to address 2 commits, and frame_count = 1.
- Wrap: send 256 valid frames.
  - frame_count reads 255, then 0 after the 256th frame.
  - The last frame's wr_addr and wr_data are held.
